// File: rtl/instruction_cache_pkg.sv
// Shared constants and refill state encoding for the direct-mapped instruction cache.
package instruction_cache_pkg;

  localparam logic [15:0] NOP         = 16'h0000;
  localparam int          LINE_WORDS  = 4;
  localparam int          OFFSET_BITS = 2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FILL
  } refill_state_e;

endpackage

// File: rtl/icache_refill_ctrl.sv
// Miss handling for the instruction cache: latches the missing line, issues the
// burst request and sequences the refill beats, tracking flushes that land mid-refill.
module icache_refill_ctrl
  import instruction_cache_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int LINE_W = ADDR_W - OFFSET_BITS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   lookup_miss,
  input  logic [LINE_W-1:0]      lookup_line,
  input  logic                   flush,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [ADDR_W-1:0]      mem_req_addr,
  input  logic                   mem_rsp_valid,
  output refill_state_e          state,
  output logic [OFFSET_BITS-1:0] beat,
  output logic [LINE_W-1:0]      miss_line,
  output logic                   beat_we,
  output logic                   line_done,
  output logic                   install
);

  localparam logic [OFFSET_BITS-1:0] LAST_BEAT = OFFSET_BITS'(LINE_WORDS - 1);

  refill_state_e          state_reg, state_next;
  logic [OFFSET_BITS-1:0] beat_reg, beat_next;
  logic                   kill_reg, kill_next;
  logic [LINE_W-1:0]      miss_line_reg, miss_line_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      beat_reg      <= '0;
      kill_reg      <= 1'b0;
      miss_line_reg <= '0;
    end else begin
      state_reg     <= state_next;
      beat_reg      <= beat_next;
      kill_reg      <= kill_next;
      miss_line_reg <= miss_line_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    beat_next      = beat_reg;
    kill_next      = kill_reg;
    miss_line_next = miss_line_reg;
    beat_we        = 1'b0;
    line_done      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (lookup_miss && !flush) begin
          miss_line_next = lookup_line;
          state_next     = REQ;
        end
      end
      REQ: begin
        if (flush) kill_next = 1'b1;
        if (mem_req_ready) begin
          state_next = FILL;
          beat_next  = '0;
        end
      end
      FILL: begin
        if (flush) kill_next = 1'b1;
        if (mem_rsp_valid) begin
          beat_we   = 1'b1;
          beat_next = beat_reg + 1'b1;
          if (beat_reg == LAST_BEAT) begin
            line_done  = 1'b1;
            kill_next  = 1'b0;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A flush on the closing edge is handled by the top, where flush outranks install.
  assign install       = line_done && !kill_reg;
  assign mem_req_valid = (state_reg == REQ);
  assign mem_req_addr  = {miss_line_reg, {OFFSET_BITS{1'b0}}};
  assign state         = state_reg;
  assign beat          = beat_reg;
  assign miss_line     = miss_line_reg;

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped instruction cache: combinational same-cycle lookup on flop arrays,
// with misses refilled as a 4-word burst by icache_refill_ctrl.
module instruction_cache
  import instruction_cache_pkg::*;
#(
  parameter int INDEX_BITS = 4,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address_from_if,
  output logic [DATA_W-1:0] data_to_if,
  output logic              stall_if,
  input  logic              flush,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data
);

  localparam int LINES  = 1 << INDEX_BITS;
  localparam int TAG_W  = ADDR_W - INDEX_BITS - OFFSET_BITS;
  localparam int LINE_W = ADDR_W - OFFSET_BITS;

  logic [OFFSET_BITS-1:0] offset;
  logic [INDEX_BITS-1:0]  index;
  logic [TAG_W-1:0]       tag;
  assign {tag, index, offset} = address_from_if;

  logic              valid_reg [LINES];
  logic [TAG_W-1:0]  tag_reg   [LINES];
  logic [DATA_W-1:0] data_reg  [LINES][LINE_WORDS];

  refill_state_e          state;
  logic [OFFSET_BITS-1:0] beat;
  logic [LINE_W-1:0]      miss_line;
  logic [INDEX_BITS-1:0]  miss_index;
  logic [TAG_W-1:0]       miss_tag;
  logic                   beat_we, line_done, install;
  logic                   line_match, hit;

  assign {miss_tag, miss_index} = miss_line;

  assign line_match = valid_reg[index] && (tag_reg[index] == tag);
  assign hit        = line_match && (state == IDLE);
  assign stall_if   = !hit;
  assign data_to_if = hit ? data_reg[index][offset] : DATA_W'(NOP);

  icache_refill_ctrl #(
    .ADDR_W (ADDR_W),
    .LINE_W (LINE_W)
  ) u_refill (
    .clk           (clk),
    .rst_n         (rst_n),
    .lookup_miss   (!line_match),
    .lookup_line   ({tag, index}),
    .flush         (flush),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .state         (state),
    .beat          (beat),
    .miss_line     (miss_line),
    .beat_we       (beat_we),
    .line_done     (line_done),
    .install       (install)
  );

  generate
    for (genvar gi = 0; gi < LINES; gi++) begin : g_line
      // Flush has priority so a flush on the last beat leaves the line invalid.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          valid_reg[gi] <= 1'b0;
        else if (flush)
          valid_reg[gi] <= 1'b0;
        else if (install && miss_index == INDEX_BITS'(gi))
          valid_reg[gi] <= 1'b1;
      end

      always_ff @(posedge clk) begin
        if (line_done && miss_index == INDEX_BITS'(gi))
          tag_reg[gi] <= miss_tag;
      end

      for (genvar gw = 0; gw < LINE_WORDS; gw++) begin : g_word
        always_ff @(posedge clk) begin
          if (beat_we && miss_index == INDEX_BITS'(gi) && beat == OFFSET_BITS'(gw))
            data_reg[gi][gw] <= mem_rsp_data;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_instruction_cache.sv
// Randomized self-checking bench for instruction_cache against a line-level cache model
// and a flat backing-memory array; the bench itself plays the memory side.
module tb_instruction_cache;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] address_from_if = 16'h0005;
  logic [15:0] data_to_if;
  logic        stall_if;
  logic        flush = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [15:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [15:0] mem_rsp_data = 16'h0000;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem [65536];
  bit          mvalid [16];
  logic [9:0]  mtag [16];

  always #5 clk = ~clk;

  instruction_cache #(
    .INDEX_BITS (4),
    .ADDR_W     (16),
    .DATA_W     (16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .address_from_if (address_from_if),
    .data_to_if      (data_to_if),
    .stall_if        (stall_if),
    .flush           (flush),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_addr    (mem_req_addr),
    .mem_rsp_valid   (mem_rsp_valid),
    .mem_rsp_data    (mem_rsp_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_hit(input logic [15:0] a);
    return mvalid[a[5:2]] && (mtag[a[5:2]] == a[15:6]);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
  endfunction

  // One fetch: present address a, act as memory until the cache hits.
  // w = ready-low cycles before accept, g = idle cycles before beat 2,
  // fb = beat index carrying a flush pulse (-1 = none); all apply to the first refill only.
  task automatic fetch(input logic [15:0] a, input int w, input int g, input int fb);
    int          stalls = 0;
    int          exp_stalls = 0;
    int          rounds = 0;
    bit          done = 1'b0;
    bit          killed;
    int          wr, gr;
    logic [15:0] base;
    base = a & 16'hFFFC;
    @(negedge clk);
    address_from_if = a;
    flush           = 1'b0;
    mem_req_ready   = 1'b0;
    mem_rsp_valid   = 1'($urandom_range(0, 1));
    mem_rsp_data    = 16'($urandom);
    #1;
    for (int r = 0; r < 4 && !done; r++) begin
      rounds++;
      if (model_hit(a)) begin
        check("hit_stall", stall_if, 0);
        check("hit_data", data_to_if, mem[a]);
        check("hit_noreq", mem_req_valid, 0);
        done = 1'b1;
      end else begin
        wr = (r == 0) ? w : 0;
        gr = (r == 0) ? g : 0;
        exp_stalls += 6 + wr + gr;
        killed = 1'b0;
        check("miss_data", data_to_if, 16'h0000);
        stalls += int'(stall_if);
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        for (int i = 0; i <= wr; i++) begin
          if (i > 0) @(negedge clk);
          mem_req_ready = (i == wr);
          #1;
          check("req_valid", mem_req_valid, 1);
          check("req_addr", mem_req_addr, base);
          stalls += int'(stall_if);
        end
        for (int b = 0; b < 4; b++) begin
          if (b == 2) begin
            for (int k = 0; k < gr; k++) begin
              @(negedge clk);
              mem_req_ready = 1'b0;
              mem_rsp_valid = 1'b0;
              flush         = 1'b0;
              #1;
              stalls += int'(stall_if);
            end
          end
          @(negedge clk);
          mem_req_ready = 1'b0;
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = mem[base + 16'(b)];
          flush         = (r == 0) && (fb == b);
          if (flush) killed = 1'b1;
          #1;
          stalls += int'(stall_if);
        end
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        flush         = 1'b0;
        if (killed) begin
          model_clear();
        end else begin
          mvalid[a[5:2]] = 1'b1;
          mtag[a[5:2]]   = a[15:6];
        end
        #1;
      end
    end
    if (!done) check("fetch_timeout", 0, 1);
    check("stall_cycles", stalls, exp_stalls);
    $display("fetch addr=%h rounds=%0d stalls=%0d data=%h", a, rounds, stalls, data_to_if);
  endtask

  // Flush while idle: this cycle's lookup is unaffected, every line is gone afterwards.
  task automatic flush_idle();
    bit was_hit;
    @(negedge clk);
    flush         = 1'b1;
    mem_rsp_valid = 1'b0;
    #1;
    was_hit = model_hit(address_from_if);
    check("flush_cycle_stall", stall_if, !was_hit);
    model_clear();
    $display("flush idle addr=%h", address_from_if);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[4] = 16'hA000;
    mem[5] = 16'hA001;
    mem[6] = 16'hA002;
    mem[7] = 16'hA003;
    model_clear();

    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", stall_if, 1);
    check("rst_data", data_to_if, 16'h0000);
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_req_addr", mem_req_addr, 16'h0000);
    rst_n = 1'b1;

    // Cold miss, sequential hits, conflict eviction.
    fetch(16'h0005, 0, 0, -1);
    for (int i = 4; i < 8; i++) fetch(16'(i), 0, 0, -1);
    fetch(16'h0044, 0, 0, -1);
    fetch(16'h0004, 0, 0, -1);

    // Back-pressure, flush mid-fill, flush on the last beat, flush while idle.
    fetch(16'h0232, 3, 2, -1);
    fetch(16'h0351, 0, 0, 2);
    fetch(16'h0362, 1, 1, 3);
    fetch(16'h0232, 0, 0, -1);
    flush_idle();
    fetch(16'h0232, 0, 0, -1);

    // Reset while a request is pending.
    @(negedge clk);
    address_from_if = 16'h0100;
    flush           = 1'b0;
    mem_rsp_valid   = 1'b0;
    #1;
    check("pre_rst_stall", stall_if, 1);
    @(negedge clk);
    #1;
    check("pre_rst_req", mem_req_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_req", mem_req_valid, 0);
    check("async_rst_addr", mem_req_addr, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    #1;
    check("post_rst_stall", stall_if, 1);
    check("post_rst_data", data_to_if, 16'h0000);
    $display("reset mid-request addr=%h", address_from_if);
    fetch(16'h0100, 0, 0, -1);

    // Random traffic over a few tags so hits, conflicts and flushes mix.
    for (int n = 0; n < 60; n++) begin
      logic [15:0] a;
      int          fb;
      a  = (16'($urandom_range(0, 3)) << 6) | 16'($urandom_range(0, 63));
      fb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
      if ($urandom_range(0, 14) == 0) flush_idle();
      fetch(a, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), fb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instruction_cache.md
# instruction_cache

Direct-mapped instruction cache that answers the fetch stage's per-cycle word address. It returns the instruction combinationally in the same cycle on a hit, and raises a stall on a miss. Misses are refilled with a 4-word burst from backing memory through a valid/ready request channel and a valid-only response channel. The block sits between the fetch stage's address/instruction port and the main memory bus.

## Interface
Parameters:
- INDEX_BITS, 4, number of line-index bits (2^INDEX_BITS lines).
- ADDR_W, 16, word-address width.
- DATA_W, 16, instruction width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- address_from_if  in  ADDR_W  word address from fetch (PC).
- data_to_if  out  DATA_W  instruction for address_from_if; NOP (16'h0000) when not a hit.
- stall_if  out  1  1 = data_to_if not valid, fetch must hold its PC.
- flush  in  1  invalidate all lines.
- mem_req_valid  out  1  refill request pending.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  ADDR_W  line base address, low 2 bits zero.
- mem_rsp_valid  in  1  one refill beat present.
- mem_rsp_data  in  DATA_W  refill beat data, in ascending word order.

## Operation
- **Address split:** offset = addr[1:0]; index = addr[INDEX_BITS+1:2]; tag = addr[ADDR_W-1:INDEX_BITS+2] (10 bits at defaults).
- **Storage:** valid[2^INDEX_BITS], tag array, data array of 4 words per line. All are flops, read combinationally.
- **Hit:** valid[index] && tag match && state==IDLE. On a hit, data_to_if = word and stall_if = 0. Otherwise stall_if = 1 and data_to_if = NOP.
- **FSM states:** IDLE, REQ, FILL.
  - **IDLE:** on a miss with flush=0, latch miss_line = {tag, index} and go to REQ.
  - **REQ:** mem_req_valid = 1, mem_req_addr = {miss_line, 2'b00}. On mem_req_valid && mem_req_ready, go to FILL with beat = 0.
  - **FILL:** each mem_rsp_valid writes mem_rsp_data into data[miss_index][beat], then beat++. On beat 3, write tag, set valid (unless kill is set), clear kill, and return to IDLE.
- mem_rsp_valid outside FILL is ignored. There is no response back-pressure; every beat in FILL is accepted.
- **Flush:**
  - In IDLE: clears all valid bits at the edge, and no miss is started that cycle.
  - In REQ or FILL: clears all valid bits and sets kill. The burst still completes, but the refilled line is left invalid.
- **Address change while stalled:** fetch must hold the address, but the cache does not depend on it. The refill targets the latched miss_line, and lookup re-evaluates the current address in IDLE.
- **Reset (async):** state = IDLE, all valid = 0, beat = 0, kill = 0, mem_req_valid = 0, mem_req_addr = 0. Outputs after reset are data_to_if = NOP and stall_if = 1, since every lookup misses. Reset mid-burst abandons the burst; any remaining beats arrive outside FILL and are ignored.

## Timing
- **Hit latency:** 0 cycles. Data is combinational from address_from_if and is captured by fetch at the next edge.
- **Miss penalty:**
  - Miss seen in cycle 0 (IDLE).
  - REQ is asserted from cycle 1.
  - With ready in cycle 1 and back-to-back beats in cycles 2..5, the line becomes valid at the edge ending cycle 5.
  - The hit appears in cycle 6: minimum 6 cycles of stall_if.
- mem_req_valid, once raised, stays high with a stable mem_req_addr until accepted.
- Beat gaps (mem_rsp_valid = 0) stall FILL without limit.
- **Same-edge events:** flush and the last beat on the same edge leaves the line invalid.

## Structure
- Shared package holds:
  - NOP = 16'h0000
  - LINE_WORDS = 4
  - OFFSET_BITS = 2
  - the state enum (IDLE, REQ, FILL)
- One sub-module, icache_refill_ctrl, holds the FSM, beat counter, kill flag, miss_line latch and request handshake. The top level holds the arrays and the hit/lookup logic.

## Test plan
- **Cold miss:** reset, address 16'h0005, memory gives ready immediately and beats 16'hA000..A003.
  - Required: mem_req_addr = 16'h0004, stall_if high for 6 cycles, then data_to_if = 16'hA001 with stall_if = 0.
- **Sequential hits:** after the fill above, addresses 16'h0004..0007.
  - Required: data A000..A003, stall_if = 0 every cycle, mem_req_valid never asserts.
- **Conflict:** after the fill, address 16'h0044 (same index, different tag).
  - Required: a new refill to 16'h0044; afterwards 16'h0004 misses again.
- **Back-pressure:** hold mem_req_ready = 0 for 3 cycles and insert 2 idle cycles between beats.
  - Required: mem_req_valid and mem_req_addr are stable while waiting, and stall extends by exactly 5 cycles.
- **Flush mid-FILL:** pulse flush after beat 1.
  - Required: all 4 beats are consumed, the line is invalid, and the same address misses again and triggers a new request.
- **Reset mid-REQ:** assert rst_n = 0 while mem_req_valid = 1.
  - Required: mem_req_valid drops immediately (async), and after release stall_if = 1 and data_to_if = 16'h0000.
